// File: rtl/vluint_pkg.sv
// Shared constants and types for the vluint7 LEB128-style encoder and decoder.
// The decoder imports the same package so both sides agree on group size and flag position.
package vluint_pkg;

  localparam int VLU_GRP_BITS = 7;
  localparam int VLU_CONT_BIT = 7;

  typedef enum logic [1:0] {
    VLU_IDLE,
    VLU_EMIT,
    VLU_DONE
  } vlu_state_t;

  function automatic int vlu_max_bytes(input int w);
    return (w + 6) / 7;
  endfunction

endpackage

// File: rtl/vluint7_enc.sv
// Unsigned variable-length encoder: writes one word as 7-bit groups, LSB group first,
// one byte per cycle into byte-wide memory, bit 7 flagging that another byte follows.
module vluint7_enc
  import vluint_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beg,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] data,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr_out,
  output logic [2:0]        nbytes
);

  localparam int MAX_BYTES = vlu_max_bytes(WORD_W);

  if (BYTE_W != 8) begin : g_byte_w_check
    $error("vluint7_enc: BYTE_W must be 8");
  end

  vlu_state_t        r_state;
  vlu_state_t        w_next;
  logic [WORD_W-1:0] r_rem;
  logic [ADDR_W-1:0] r_ptr;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr_out;
  logic [2:0]        r_nbytes;

  logic w_cont;
  logic w_accept;
  logic w_start;
  logic w_we;
  logic w_busy;
  logic w_done;

  // Continuation is set whenever any bits remain above the group being written.
  assign w_cont    = |r_rem[WORD_W-1:VLU_GRP_BITS];
  assign w_accept  = (r_state == VLU_EMIT) && mem_ready;
  assign w_start   = beg && (r_state != VLU_EMIT);

  assign mem_we    = w_we;
  assign busy      = w_busy;
  assign done      = w_done;
  assign mem_addr  = r_ptr;
  assign mem_wdata = {w_cont, r_rem[VLU_GRP_BITS-1:0]};
  assign addr_out  = r_addr_out;
  assign nbytes    = r_nbytes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= VLU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      VLU_IDLE: begin
        if (beg) w_next = VLU_EMIT;
      end
      VLU_EMIT: begin
        w_we   = 1'b1;
        w_busy = 1'b1;
        if (mem_ready && !w_cont) w_next = VLU_DONE;
      end
      VLU_DONE: begin
        w_done = 1'b1;
        w_next = beg ? VLU_EMIT : VLU_IDLE;
      end
      default: w_next = VLU_IDLE;
    endcase
  end

  // Result registers update on the last accepted byte so they are valid alongside done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem      <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_addr_out <= '0;
      r_nbytes   <= '0;
    end else if (w_start) begin
      r_rem <= data;
      r_ptr <= addr;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_rem <= r_rem >> VLU_GRP_BITS;
      r_ptr <= r_ptr + ADDR_W'(1);
      r_cnt <= r_cnt + 3'd1;
      if (!w_cont) begin
        r_addr_out <= r_ptr + ADDR_W'(1);
        r_nbytes   <= r_cnt + 3'd1;
      end
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset) int'(r_cnt) <= MAX_BYTES);

endmodule
